// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: turns a raster pixel stream into interior
// 3x3 windows using two line buffers and a register window.
module conv_window_gen #(
    parameter int BITW  = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [BITW-1:0] in_pix,
    input  logic            in_sof,
    output logic [BITW-1:0] u00,
    output logic [BITW-1:0] u01,
    output logic [BITW-1:0] u02,
    output logic [BITW-1:0] u10,
    output logic [BITW-1:0] u11,
    output logic [BITW-1:0] u12,
    output logic [BITW-1:0] u20,
    output logic [BITW-1:0] u21,
    output logic [BITW-1:0] u22,
    output logic            out_valid,
    output logic            out_eof,
    output logic            frame_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]   col_reg, col_eff, col_next;
    logic [RW-1:0]   row_reg, row_eff, row_next;
    logic            col_last, row_last, win_ok, pos_nonzero;
    logic [BITW-1:0] rd0, rd1;
    logic [BITW-1:0] col_in [3];

    // lb0 holds row r-2, lb1 holds row r-1; not reset, contents are don't-care
    logic [BITW-1:0] lb0 [IMG_W];
    logic [BITW-1:0] lb1 [IMG_W];

    logic [BITW-1:0] win_reg [3][3];

    // A qualified sof pins the current pixel to (0,0) regardless of counters
    always_comb begin
        col_eff     = in_sof ? '0 : col_reg;
        row_eff     = in_sof ? '0 : row_reg;
        col_last    = (col_eff == CW'(IMG_W - 1));
        row_last    = (row_eff == RW'(IMG_H - 1));
        col_next    = col_last ? '0 : col_eff + CW'(1);
        row_next    = row_eff;
        if (col_last) begin
            row_next = row_last ? '0 : row_eff + RW'(1);
        end
        win_ok      = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
        pos_nonzero = (col_reg != '0) || (row_reg != '0);
        rd0         = lb0[col_eff];
        rd1         = lb1[col_eff];
        col_in[0]   = rd0;
        col_in[1]   = rd1;
        col_in[2]   = in_pix;
    end

    // Read-before-write: rd0/rd1 above see the old contents this cycle
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb0[col_eff] <= rd1;
            lb1[col_eff] <= in_pix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg   <= '0;
            row_reg   <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= in_valid && win_ok;
            out_eof   <= in_valid && row_last && col_last;
            if (in_valid) begin
                col_reg <= col_next;
                row_reg <= row_next;
                if (in_sof && pos_nonzero) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_reg[i][j] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                win_reg[i][0] <= win_reg[i][1];
                win_reg[i][1] <= win_reg[i][2];
                win_reg[i][2] <= col_in[i];
            end
        end
    end

    assign u00 = win_reg[0][0];
    assign u01 = win_reg[0][1];
    assign u02 = win_reg[0][2];
    assign u10 = win_reg[1][0];
    assign u11 = win_reg[1][1];
    assign u12 = win_reg[1][2];
    assign u20 = win_reg[2][0];
    assign u21 = win_reg[2][1];
    assign u22 = win_reg[2][2];

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Producer side of the 3x3 window interface consumed by the pipelined 3x3 convolver.
- Accepts a raster-scan pixel stream, one pixel per valid cycle.
- Stores the two previous image rows in line buffers and a 3x3 register window.
- Presents the nine window pixels u00..u22 plus a valid strobe, so they connect directly to the convolver's window inputs and in_valid.
- Only fully-interior windows are emitted; there is no border padding.

Parameters:
BITW, 8, pixel width in bits
IMG_W, 640, pixels per row (must be at least 3)
IMG_H, 480, rows per frame (must be at least 3)

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel strobe; in_pix is sampled when high
in_pix  input  BITW  unsigned pixel, raster order (row-major, left to right)
in_sof  input  1  start-of-frame; qualified by in_valid, marks pixel (0,0)
u00,u01,u02  output  BITW each  window row r-2, columns c-2, c-1, c
u10,u11,u12  output  BITW each  window row r-1, columns c-2, c-1, c
u20,u21,u22  output  BITW each  window row r, columns c-2, c-1, c
out_valid  output  1  window valid, one-cycle pulse per window
out_eof  output  1  high together with out_valid on the last window of a frame
frame_err  output  1  sticky flag: in_sof arrived while position was not (0,0)

Behaviour:
- Reset (rst_n low, asynchronous):
  - Row and column counters go to 0.
  - All window registers, outputs, out_valid, out_eof and frame_err go to 0.
  - Line buffer contents are not reset; they are don't-care until overwritten.
- Stall: in_valid low freezes the counters, window, line buffers and all outputs except out_valid and out_eof, which drop to 0. Bubbles are allowed anywhere.
- Accepted pixel at position (r,c), where in_valid is high:
  - rd1 = lb1[c] (row r-1) and rd0 = lb0[c] (row r-2).
  - Writes: lb0[c] <= rd0_source lb1[c]; lb1[c] <= in_pix.
  - Window columns shift left: u*0 <= u*1, u*1 <= u*2.
  - New right column: u02 <= rd0, u12 <= rd1, u22 <= in_pix.
  - Line buffer read and write happen in the same cycle at the same address. This is read-before-write: old data is read. The design uses registers or a read-first RAM.
- Counters:
  - c increments on each accepted pixel and wraps to 0 at IMG_W-1.
  - When c wraps, r increments; r wraps to 0 at IMG_H-1 (end of frame).
  - Counter widths are clog2 of IMG_W and clog2 of IMG_H.
- out_valid timing:
  - Registered, latency 1 cycle: out_valid is high in the cycle after an accepted pixel with r >= 2 and c >= 2.
  - The window shows the new pixel in u22 during that same cycle.
  - Windows do not straddle rows. For c = 0 or 1, out_valid stays 0 even though the window holds stale columns.
  - Windows per frame = (IMG_W-2)*(IMG_H-2).
- out_eof is high with out_valid for the pixel (IMG_H-1, IMG_W-1).
- in_sof handling:
  - With in_valid high, in_sof forces this pixel to be treated as (0,0). Counters continue from (0,1).
  - If the counters were not at (0,0), frame_err is set. It is sticky until reset.
  - Rows from before the sof are discarded logically: no window is emitted until r >= 2 of the new frame.
- Frame-to-frame:
  - Back-to-back frames need no gap.
  - Line buffer data from the previous frame is never used in a valid window, because of the r >= 2 gate.
- Reset mid-frame: the next accepted pixel is (0,0) whether or not in_sof is high.
- in_sof with in_valid low is ignored.

Test Plan:
- IMG_W=4, IMG_H=4, pixel = 16*r + c, contiguous stream with in_sof on the first pixel.
  - Exactly 4 out_valid pulses, the first 1 cycle after pixel 0x22.
  - First window: u00..u22 = 00,01,02 / 10,11,12 / 20,21,22.
  - Last window = 11,12,13 / 21,22,23 / 31,32,33, with out_eof = 1.
- Same image with in_valid toggling 1-0-1 (random bubbles).
  - Identical sequence of 4 windows; out_valid never high in a bubble cycle.
- Two back-to-back 4x4 frames, second frame pixel = 0x80 + 16*r + c.
  - 8 windows in total.
  - The 5th window is 80,81,82 / 90,91,92 / A0,A1,A2, with no first-frame data.
  - frame_err stays 0.
- Drive rst_n low for 1 cycle after pixel (2,1), then restart the stream without in_sof.
  - Outputs read 0 immediately (asynchronously).
  - The next pixel is treated as (0,0); the first window appears after the new (2,2).
- Assert in_sof at pixel (1,3) of a 4x4 frame.
  - frame_err goes to 1 and stays there.
  - The counters resync; the first window appears after the 11th pixel counted from the sof pixel (position (2,2)).
- IMG_W=5, IMG_H=3 ramp.
  - Exactly 3 windows, at columns 2, 3 and 4 of row 2.
  - out_eof on the 3rd window.
  - No windows in rows 0 and 1.
